pipelined_skid_register: RTL and testbench
==========================================

PIPELINED_SKID_REGISTER -- requirements
Module: pipelined_skid_register

Interface
REQ-001 Parameter DATA_W, default 32: width of the payload field (operands, addresses, PC).
REQ-002 Parameter CTRL_W, default 16: width of the control field (ALU op, size, RF/MEM enables).
REQ-003 Clk  input  1  sole clock; all state updates on posedge Clk.
REQ-004 R_n  input  1  asynchronous active-low reset.
REQ-005 in_valid  input  1  upstream stage presents an entry.
REQ-006 in_ready  output  1  block can accept an entry this cycle.
REQ-007 in_data  input  DATA_W  upstream payload.
REQ-008 in_ctrl  input  CTRL_W  upstream control bits.
REQ-009 out_valid  output  1  downstream entry is valid.
REQ-010 out_ready  input  1  downstream consumes out entry this cycle.
REQ-011 out_data  output  DATA_W  payload of head entry.
REQ-012 out_ctrl  output  CTRL_W  control bits of head entry; all-zero when out_valid=0 (bubble).
REQ-013 flush  input  1  synchronous squash of all held entries (branch/hazard).
REQ-014 occupancy  output  2  number of held entries, 0..2.

Function
REQ-015 Accept = in_valid & in_ready; pop = out_valid & out_ready; both evaluated at posedge Clk.
REQ-016 Storage: main slot (drives out_*) and skid slot; state machine EMPTY, ONE, FULL.
REQ-017 EMPTY: accept -> ONE, entry loaded into main; otherwise stay.
REQ-018 ONE: accept & pop -> ONE, main reloaded; accept & !pop -> FULL, entry into skid; !accept & pop -> EMPTY; else hold.
REQ-019 FULL: pop -> ONE, skid moved to main; no accept possible; else hold.
REQ-020 in_ready = 1 in EMPTY and ONE, 0 in FULL; driven from flop state only, with no combinational path from out_ready.
REQ-021 out_valid = 1 in ONE and FULL; occupancy = 0/1/2 for EMPTY/ONE/FULL.
REQ-022 Latency from accept to out_valid when EMPTY: 1 cycle; sustained throughput 1 entry/cycle with out_ready held 1.
REQ-023 Order preserved: entries leave in acceptance order; no entry duplicated or dropped except by flush.
REQ-024 flush has highest priority: next state EMPTY, any same-cycle accept discarded, pop in that cycle ignored for state purposes.
REQ-025 out_data holds last main value when out_valid=0; out_ctrl forced to 0 whenever out_valid=0.
REQ-026 Stable output: while out_valid=1 and out_ready=0, out_data/out_ctrl unchanged.

Reset
REQ-027 R_n=0 asynchronously forces EMPTY, both slots' data and ctrl to 0, out_valid=0, in_ready=1, occupancy=0.
REQ-028 Reset mid-operation discards all entries; first accept after R_n release behaves as from EMPTY.

Structure
REQ-029 Shared package pipe_pkg holds the state enum (EMPTY, ONE, FULL) and default DATA_W/CTRL_W constants.
REQ-030 One sub-module, pipelined_slot: DATA_W+CTRL_W register with load enable and async clear, instantiated as main and skid.

Verification
REQ-031 Stream 0x11,0x22,0x33 with out_ready=1 -> out_data 0x11,0x22,0x33 on consecutive cycles, 1 cycle after each accept.
REQ-032 Accept 0xA1, out_ready=0, accept 0xB2 -> occupancy=2, in_ready=0, out_data=0xA1 stable; release -> 0xA1 then 0xB2.
REQ-033 FULL with ctrl 0x00FF, assert flush -> next cycle out_valid=0, out_ctrl=0x0000, occupancy=0, in_ready=1.
REQ-034 flush and in_valid (0x55) same cycle -> 0x55 never appears on out_data with out_valid=1.
REQ-035 R_n low while FULL -> immediately out_valid=0, in_ready=1, out_data=0; after release accept 0x77 -> out 0x77 next cycle.
REQ-036 Random valid/ready, 10k entries -> scoreboard order match, no loss; in_ready never depends on same-cycle out_ready.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for the pipelined skid register: occupancy states and
// default field widths.
package pipe_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_CTRL_W = 16;

    // The state encodes how many entries are currently held.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    // Number of held entries for a given state.
    function automatic logic [1:0] occupancy_of(input state_t s);
        case (s)
            ONE:     occupancy_of = 2'd1;
            FULL:    occupancy_of = 2'd2;
            default: occupancy_of = 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/pipelined_slot.sv
// One storage slot: payload plus control bits, loaded on enable and cleared
// asynchronously by reset.
module pipelined_slot #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 16
) (
    input  logic              Clk,
    input  logic              R_n,
    input  logic              load,
    input  logic [DATA_W-1:0] d_data,
    input  logic [CTRL_W-1:0] d_ctrl,
    output logic [DATA_W-1:0] q_data,
    output logic [CTRL_W-1:0] q_ctrl
);

    logic [DATA_W-1:0] data_q, data_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;

    // Capture new contents only when enabled; otherwise hold.
    always_comb begin
        data_d = data_q;
        ctrl_d = ctrl_q;
        if (load) begin
            data_d = d_data;
            ctrl_d = d_ctrl;
        end
    end

    // Slot register with asynchronous clear.
    always_ff @(posedge Clk or negedge R_n) begin
        if (!R_n) begin
            data_q <= '0;
            ctrl_q <= '0;
        end else begin
            data_q <= data_d;
            ctrl_q <= ctrl_d;
        end
    end

    assign q_data = data_q;
    assign q_ctrl = ctrl_q;

endmodule

// File: rtl/pipelined_skid_register.sv
// Two-entry pipeline register with a skid slot. The main slot drives the
// outputs; the skid slot absorbs one extra entry so that in_ready can be a
// pure function of registered state, breaking the out_ready -> in_ready path.
module pipelined_skid_register
    import pipe_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int CTRL_W = DEF_CTRL_W
) (
    input  logic              Clk,
    input  logic              R_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    input  logic              flush,
    output logic [1:0]        occupancy
);

    state_t state_q, state_d;

    logic              accept;
    logic              pop;
    logic              main_load;
    logic              main_from_skid;
    logic              skid_load;
    logic [DATA_W-1:0] main_d_data, main_q_data, skid_q_data;
    logic [CTRL_W-1:0] main_d_ctrl, main_q_ctrl, skid_q_ctrl;

    // Handshake status depends only on the state register.
    assign in_ready  = (state_q != FULL);
    assign out_valid = (state_q != EMPTY);
    assign occupancy = occupancy_of(state_q);
    assign accept    = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    // Next-state and slot load control; flush overrides every other event.
    always_comb begin
        state_d        = state_q;
        main_load      = 1'b0;
        main_from_skid = 1'b0;
        skid_load      = 1'b0;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (accept) begin
                        state_d   = ONE;
                        main_load = 1'b1;
                    end
                end
                ONE: begin
                    if (accept && pop) begin
                        main_load = 1'b1;
                    end else if (accept) begin
                        state_d   = FULL;
                        skid_load = 1'b1;
                    end else if (pop) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    if (pop) begin
                        state_d        = ONE;
                        main_load      = 1'b1;
                        main_from_skid = 1'b1;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    // State register.
    always_ff @(posedge Clk or negedge R_n) begin
        if (!R_n) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Main slot is refilled either from upstream or from the skid slot.
    always_comb begin
        main_d_data = in_data;
        main_d_ctrl = in_ctrl;
        if (main_from_skid) begin
            main_d_data = skid_q_data;
            main_d_ctrl = skid_q_ctrl;
        end
    end

    pipelined_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_main (
        .Clk    (Clk),
        .R_n    (R_n),
        .load   (main_load),
        .d_data (main_d_data),
        .d_ctrl (main_d_ctrl),
        .q_data (main_q_data),
        .q_ctrl (main_q_ctrl)
    );

    pipelined_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_skid (
        .Clk    (Clk),
        .R_n    (R_n),
        .load   (skid_load),
        .d_data (in_data),
        .d_ctrl (in_ctrl),
        .q_data (skid_q_data),
        .q_ctrl (skid_q_ctrl)
    );

    // Data keeps its last value during bubbles; control reads as zero.
    assign out_data = main_q_data;
    assign out_ctrl = out_valid ? main_q_ctrl : '0;

endmodule

// File: tb/tb_pipelined_skid_register.sv
// Self-checking bench for pipelined_skid_register: a queue-based model of a
// two-entry FIFO with flush, directed scenarios and a long random run.
module tb_pipelined_skid_register;

    localparam int DW = 32;
    localparam int CW = 16;

    typedef struct packed {
        logic [DW-1:0] d;
        logic [CW-1:0] c;
    } ent_t;

    logic          Clk = 1'b0;
    logic          R_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_data = '0;
    logic [CW-1:0] in_ctrl = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_data;
    logic [CW-1:0] out_ctrl;
    logic          flush = 1'b0;
    logic [1:0]    occupancy;

    int checks = 0;
    int errors = 0;

    // Model state: FIFO contents and the value last presented as head.
    ent_t          mq[$];
    logic [DW-1:0] last_head = '0;
    int            accepted = 0;
    int            popped   = 0;

    pipelined_skid_register #(.DATA_W(DW), .CTRL_W(CW)) dut (
        .Clk       (Clk),
        .R_n       (R_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_ctrl   (in_ctrl),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ctrl  (out_ctrl),
        .flush     (flush),
        .occupancy (occupancy)
    );

    always #5 Clk = ~Clk;

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not complete, got running required finished");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h required 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare every DUT output with what the model says it must be.
    task automatic compare_all();
        chk("occupancy", 64'(occupancy), 64'(mq.size()));
        chk("out_valid", 64'(out_valid), 64'(mq.size() > 0));
        chk("in_ready",  64'(in_ready),  64'(mq.size() < 2));
        if (mq.size() > 0) begin
            chk("out_data", 64'(out_data), 64'(mq[0].d));
            chk("out_ctrl", 64'(out_ctrl), 64'(mq[0].c));
        end else begin
            chk("bubble_data", 64'(out_data), 64'(last_head));
            chk("bubble_ctrl", 64'(out_ctrl), 64'd0);
        end
    endtask

    // One clock cycle: drive at negedge, advance model at posedge, check at
    // the following negedge. in_ready is probed against an out_ready toggle.
    task automatic cycle(input logic iv, input logic [DW-1:0] d, input logic [CW-1:0] c,
                         input logic ordy, input logic fl);
        logic rdy_before;
        logic acc;
        logic pp;
        in_valid  = iv;
        in_data   = d;
        in_ctrl   = c;
        out_ready = ordy;
        flush     = fl;
        #1;
        rdy_before = in_ready;
        out_ready  = ~ordy;
        #1;
        chk("in_ready_vs_out_ready", 64'(in_ready), 64'(rdy_before));
        out_ready = ordy;
        @(posedge Clk);
        acc = iv && (mq.size() < 2);
        pp  = (mq.size() > 0) && ordy;
        if (fl) begin
            mq.delete();
        end else begin
            if (pp) begin
                void'(mq.pop_front());
                popped++;
            end
            if (acc) begin
                mq.push_back('{d: d, c: c});
                accepted++;
            end
        end
        if (mq.size() > 0) last_head = mq[0].d;
        @(negedge Clk);
        compare_all();
    endtask

    task automatic idle(input logic ordy);
        cycle(1'b0, '0, '0, ordy, 1'b0);
    endtask

    initial begin
        int cyc;
        // Reset state while R_n is held low.
        #3;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready",  64'(in_ready),  64'd1);
        chk("rst_occupancy", 64'(occupancy), 64'd0);
        chk("rst_out_data",  64'(out_data),  64'd0);
        chk("rst_out_ctrl",  64'(out_ctrl),  64'd0);
        @(negedge Clk);
        @(negedge Clk);
        R_n = 1'b1;

        // Streaming at full rate: each value appears one cycle after accept.
        cycle(1'b1, 32'h11, 16'h0001, 1'b1, 1'b0);
        chk("s1_data",  64'(out_data),  64'h11);
        chk("s1_valid", 64'(out_valid), 64'd1);
        cycle(1'b1, 32'h22, 16'h0002, 1'b1, 1'b0);
        chk("s2_data", 64'(out_data), 64'h22);
        cycle(1'b1, 32'h33, 16'h0003, 1'b1, 1'b0);
        chk("s3_data", 64'(out_data), 64'h33);
        idle(1'b1);
        chk("s_drained", 64'(out_valid), 64'd0);

        // Back-pressure fills the skid slot; head stays stable.
        cycle(1'b1, 32'hA1, 16'h00A1, 1'b0, 1'b0);
        cycle(1'b1, 32'hB2, 16'h00B2, 1'b0, 1'b0);
        chk("bp_occ",      64'(occupancy), 64'd2);
        chk("bp_in_ready", 64'(in_ready),  64'd0);
        chk("bp_head",     64'(out_data),  64'hA1);
        cycle(1'b1, 32'hC3, 16'h00C3, 1'b0, 1'b0);
        chk("bp_hold",     64'(out_data),  64'hA1);
        idle(1'b1);
        chk("bp_next",     64'(out_data),  64'hB2);
        idle(1'b1);
        chk("bp_empty",    64'(occupancy), 64'd0);

        // Flush from FULL.
        cycle(1'b1, 32'h1, 16'h00FF, 1'b0, 1'b0);
        cycle(1'b1, 32'h2, 16'h00FF, 1'b0, 1'b0);
        chk("fl_ctrl_pre", 64'(out_ctrl), 64'h00FF);
        cycle(1'b0, '0, '0, 1'b0, 1'b1);
        chk("fl_valid", 64'(out_valid), 64'd0);
        chk("fl_ctrl",  64'(out_ctrl),  64'd0);
        chk("fl_occ",   64'(occupancy), 64'd0);
        chk("fl_ready", 64'(in_ready),  64'd1);

        // Flush and accept in the same cycle: the entry must vanish.
        cycle(1'b1, 32'h55, 16'h0055, 1'b1, 1'b1);
        chk("fa_valid", 64'(out_valid), 64'd0);
        idle(1'b1);
        chk("fa_valid2", 64'(out_valid), 64'd0);

        // Asynchronous reset while FULL.
        cycle(1'b1, 32'h61, 16'h0061, 1'b0, 1'b0);
        cycle(1'b1, 32'h62, 16'h0062, 1'b0, 1'b0);
        in_valid = 1'b0;
        #2;
        R_n = 1'b0;
        #1;
        mq.delete();
        last_head = '0;
        chk("ar_valid", 64'(out_valid), 64'd0);
        chk("ar_ready", 64'(in_ready),  64'd1);
        chk("ar_data",  64'(out_data),  64'd0);
        chk("ar_occ",   64'(occupancy), 64'd0);
        @(negedge Clk);
        R_n = 1'b1;
        cycle(1'b1, 32'h77, 16'h0077, 1'b1, 1'b0);
        chk("ar_first",  64'(out_data),  64'h77);
        chk("ar_fvalid", 64'(out_valid), 64'd1);
        idle(1'b1);

        // Random traffic, occasional flush, until 10k entries accepted.
        cyc = 0;
        while (accepted < 10000 && cyc < 60000) begin
            cycle(($urandom_range(0, 99) < 70), $urandom(), 16'($urandom()),
                  ($urandom_range(0, 99) < 65), ($urandom_range(0, 199) == 0));
            cyc++;
        end
        chk("random_budget", 64'(accepted >= 10000), 64'd1);
        repeat (4) idle(1'b1);
        chk("random_drained", 64'(occupancy), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
